// File: rtl/medidor_de_frecuencia_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : medidor_de_frecuencia_pkg                                 |
// | Purpose  : Shared types and constants for the frequency meter and    |
// |            its neighbours on the Nexys 3 top level (FSM encoding,    |
// |            result width, board clock, saturation helper).            |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package medidor_de_frecuencia_pkg;

  localparam int FREC_W = 8;              // result width, same scale as divider frecnum
  localparam int CNT_W  = FREC_W + 1;     // edge counter: one extra bit to hold 256
  localparam int CLK_HZ = 100_000_000;    // board clock, shared with the divider

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } estado_t;

  // The edge counter never goes past 256, so its top bit alone marks overflow.
  function automatic logic [FREC_W-1:0] saturar(input logic [CNT_W-1:0] cuenta);
    return cuenta[FREC_W] ? {FREC_W{1'b1}} : cuenta[FREC_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/medidor_de_frecuencia_sincronizador_flanco.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sincronizador_flanco                                      |
// | Purpose  : 2-FF synchronizer plus rising-edge detector for an        |
// |            asynchronous input (signals, pushbuttons).                |
// | Ports    : clk      - system clock                                   |
// |            reset    - synchronous, active-high reset                 |
// |            async_in - asynchronous input                             |
// |            rise     - one-cycle pulse on a synchronized 0->1 change  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Combinational so the pulse lines up with the cycle s2 first goes high.
  assign rise = s2 & ~s3;

endmodule
`default_nettype wire

// File: rtl/medidor_de_frecuencia.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : medidor_de_frecuencia                                     |
// | Purpose  : Frequency meter. Counts rising edges of sig_in during a   |
// |            gate window of GATE_CYCLES clk cycles and reports the     |
// |            count saturated to 8 bits (kHz at 100 MHz / 1 ms gate).   |
// | Ports    : clk, reset (sync, active-high), start (sampled in IDLE),  |
// |            sig_in (async), busy, valid (1-cycle pulse), frec_out,    |
// |            ovf (only when MEDIDOR_OVF_EN is defined).                |
// | Options  : MEDIDOR_OVF_EN adds the ovf output.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module medidor_de_frecuencia
  import medidor_de_frecuencia_pkg::*;
#(
  parameter int GATE_CYCLES = 100000,
  parameter int GATE_W      = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sig_in,
  output logic              busy,
  output logic              valid,
  output logic [FREC_W-1:0] frec_out
`ifdef MEDIDOR_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  estado_t           state;
  estado_t           state_next;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_next;
  logic              sig_rise;
  logic              gate_done;

  sincronizador_flanco u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (sig_rise)
  );

  assign gate_done = (gate_cnt == GATE_LAST);

  // Saturating edge count including the edge of the current cycle, so the
  // last cycle of the window is part of the reported result.
  assign edge_cnt_next = (sig_rise && !edge_cnt[FREC_W]) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = MEASURE;
      MEASURE: if (gate_done) state_next = REPORT;
      REPORT:                 state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs are registered and loaded on the MEASURE->REPORT transition, so
  // valid/frec_out are seen during the REPORT cycle while busy is still high.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      frec_out <= '0;
`ifdef MEDIDOR_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          edge_cnt <= edge_cnt_next;
          if (gate_done) begin
            frec_out <= saturar(edge_cnt_next);
            valid    <= 1'b1;
`ifdef MEDIDOR_OVF_EN
            ovf      <= edge_cnt_next[FREC_W];
`endif
          end
        end
        REPORT: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_medidor_de_frecuencia.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_medidor_de_frecuencia                                  |
// | Purpose  : Directed self-checking bench. Instance a uses a 100-cycle |
// |            gate, instance b a 600-cycle gate for saturation.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_medidor_de_frecuencia;

  localparam int GA = 100;
  localparam int GB = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       sig = 1'b0;
  logic       busy_a, valid_a, busy_b, valid_b;
  logic [7:0] frec_a, frec_b;
`ifdef MEDIDOR_OVF_EN
  logic       ovf_a, ovf_b;
`endif

  int half = 0;       // half period of sig in cycles; 0 = hold hold_val
  logic hold_val = 1'b0;
  int ph = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  medidor_de_frecuencia #(.GATE_CYCLES(GA), .GATE_W(7)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .sig_in(sig),
    .busy(busy_a), .valid(valid_a), .frec_out(frec_a)
`ifdef MEDIDOR_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  medidor_de_frecuencia #(.GATE_CYCLES(GB), .GATE_W(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .sig_in(sig),
    .busy(busy_b), .valid(valid_b), .frec_out(frec_b)
`ifdef MEDIDOR_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  // Signal generator, changes #1 after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (half == 0) begin
        sig = hold_val;
        ph = 0;
      end else if (ph >= half - 1) begin
        ph = 0;
        sig = ~sig;
      end else begin
        ph = ph + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One measurement: pulse start, then watch busy/valid until busy drops.
  task automatic measure(input bit sel, input int g, input int lo, input int hi, input string tag);
    int busy_n = 0;
    int valid_n = 0;
    int valid_at = -1;
    int frec = -1;
    bit done = 0;
    @(posedge clk); #2;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < g + 20 && !done; i++) begin
      @(negedge clk);
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? valid_b : valid_a) begin
        valid_n++;
        valid_at = i;
        frec = int'(sel ? frec_b : frec_a);
      end
      if (!(sel ? busy_b : busy_a)) done = 1;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_len"}, busy_n, g + 1);
    check({tag, "_valid_cnt"}, valid_n, 1);
    check({tag, "_valid_at"}, valid_at, g);
    if (lo == hi) check({tag, "_frec"}, frec, lo);
    else check({tag, "_frec_in_range"}, int'(frec >= lo && frec <= hi), 1);
  endtask

  initial begin
    int vn;
    int vt[3];
    int rst_valids;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_frec", int'(frec_a), 0);
`ifdef MEDIDOR_OVF_EN
    check("rst_ovf", int'(ovf_a), 0);
`endif

    // Period 10 over 100 cycles: 10 edges.
    half = 5;
    repeat (20) @(posedge clk);
    measure(1'b0, GA, 10, 10, "p10");
`ifdef MEDIDOR_OVF_EN
    check("p10_ovf", int'(ovf_a), 0);
`endif
    repeat (5) @(negedge clk);
    check("p10_hold", int'(frec_a), 10);

    // Period 2 over 100 cycles: 50 edges.
    half = 1;
    repeat (20) @(posedge clk);
    measure(1'b0, GA, 50, 50, "p2");

    // Held low, then held high before start: no edges either way.
    half = 0;
    hold_val = 1'b0;
    repeat (10) @(posedge clk);
    measure(1'b0, GA, 0, 0, "low");
    hold_val = 1'b1;
    repeat (10) @(posedge clk);
    measure(1'b0, GA, 0, 0, "high");

    // Period 8 (divider-like output): 12.5 edges per window -> 12 or 13.
    hold_val = 1'b0;
    half = 4;
    repeat (20) @(posedge clk);
    measure(1'b0, GA, 12, 13, "p8");

    // Period 2 over 600 cycles: 300 edges -> saturates at 255.
    half = 1;
    repeat (20) @(posedge clk);
    measure(1'b1, GB, 255, 255, "sat");
`ifdef MEDIDOR_OVF_EN
    check("sat_ovf", int'(ovf_b), 1);
`endif

    // start held high: back-to-back windows, one IDLE cycle between them.
    half = 2;
    repeat (20) @(posedge clk);
    #2 start_a = 1'b1;
    vn = 0;
    for (int i = 0; i < 3 * (GA + 2) + 30 && vn < 3; i++) begin
      @(negedge clk);
      if (valid_a) begin
        vt[vn] = i;
        vn++;
        check("b2b_frec", int'(frec_a), 25);
        if (vn == 3) start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    check("b2b_valid_cnt", vn, 3);
    if (vn == 3) begin
      check("b2b_gap1", vt[1] - vt[0], GA + 2);
      check("b2b_gap2", vt[2] - vt[1], GA + 2);
    end
    @(negedge clk);
    check("b2b_idle", int'(busy_a), 0);

    // Reset 50 cycles into MEASURE: partial count discarded, no valid.
    half = 5;
    repeat (20) @(posedge clk);
    #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (50) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_frec", int'(frec_a), 0);
    check("mid_rst_valid", int'(valid_a), 0);
    rst_valids = 0;
    for (int i = 0; i < GA + 10; i++) begin
      @(negedge clk);
      if (valid_a) rst_valids++;
    end
    check("mid_rst_no_valid", rst_valids, 0);
    measure(1'b0, GA, 10, 10, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
